core_axi_lsu_bridge: RTL and testbench
======================================

# core_axi_lsu_bridge

Parametrised bridge between a core-side valid/ready load/store port and one AXI4 manager port built from `ravenoc_pkg` `s_axi_mosi_t` / `s_axi_miso_t`. It replaces fixed single-word, single-outstanding core bus tie-offs with:
- configurable transfer size;
- multiple outstanding same-type transactions;
- a reserved-credit response buffer;
- in-order responses with error reporting.

It sits between a core's data (or instruction) bus and the NoC/AXI interconnect.

## Interface
- `MAX_OUTSTANDING`, default 2: max in-flight AXI transactions plus buffered responses; power of two, 1..8.
- `AXI_ID`, default 0: constant value driven on `arid` / `awid`.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit; used only with `CORE_AXI_LSU_BRIDGE_TIMEOUT_EN`.
- `clk` in 1: sole clock; everything on rising edge.
- `arst` in 1: reset, asynchronous assert, active-low; synchronous deassert is supplied externally.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: bridge accepts request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address, passed unaligned-unchecked.
- `req_size` in 2: AXI size encoding, 0 = byte, 1 = half, 2 = word.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: write strobes.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: core accepts response.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_err` out 1: 1 on SLVERR/DECERR (or timeout).
- `axi_miso` in `s_axi_miso_t`: AXI inputs.
- `axi_mosi` out `s_axi_mosi_t`: AXI outputs.

## Operation
- **Constant fields:**
  - `*len` = 0, `*burst` = INCR, `*lock`/`*qos`/`*region`/`*cache`/`*prot` = 0, `wlast` = 1.
  - `*size` = registered `req_size`.
  - `*id` = `AXI_ID`.
- **Holding register:** one entry (addr, we, size, wdata, wstrb) plus flags `aw_pend`, `w_pend`, `ar_pend`.
- **Request acceptance:** `req_ready` = holding empty AND credit < `MAX_OUTSTANDING` AND (`inflight` == 0 OR `req_we` == `cur_we`).
  - Mixing reads and writes therefore drains first; this guarantees in-order responses under a single ID.
- **Read issue:** accept sets `ar_pend`; `arvalid` = `ar_pend`; holding is freed on AR handshake.
- **Write issue:** accept sets `aw_pend` and `w_pend`.
  - `awvalid` and `wvalid` are driven independently.
  - Each flag clears on its own handshake; holding is freed when both are clear.
- **Counters:**
  - `credit` = in-flight + buffered responses. +1 on accept, −1 on rsp handshake.
  - `inflight` = +1 on holding-free, −1 on R/B handshake.
  - `cur_we` latched on accept.
- **Ready signals:** `rready` = `bready` = 1 whenever not in reset. Space in the response buffer is guaranteed by `credit`.
- **Response FIFO:** depth `MAX_OUTSTANDING`, entries {rdata, err}.
  - R handshake pushes {`rdata`, `rresp[1]`}.
  - B handshake pushes {0, `bresp[1]`}.
  - `rsp_*` is driven from FIFO head.
- **Simultaneous events:** accept and rsp handshake in the same cycle leave `credit` unchanged. Push and pop in the same cycle are both honoured.
- **Overflow check:** an R/B beat arriving while `inflight` == 0 is a protocol error. It is ignored and asserts a simulation-only assertion.

## Timing
- **Reset values:** all `axi_mosi` valids 0, `rready`/`bready` 0 while `arst` low; `req_ready` 0 during reset; `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0. Counters, flags and FIFO pointers are 0.
- **Request latency:** request accepted at edge N → `arvalid`/`awvalid`/`wvalid` high from cycle N+1.
- **Response latency:** R/B handshake at edge M → `rsp_valid` high from cycle M+1 (registered FIFO, no bypass).
- **Valid stability:** valids stay high with stable payload until handshake (AXI rule).
- **Peak throughput:** 1 read per cycle when `arready` is held high and credits are available.
- **Reset mid-operation:** all state is dropped immediately. Outstanding AXI transactions are abandoned; interconnect reset is expected to coincide.

## Configuration
- `CORE_AXI_LSU_BRIDGE_TIMEOUT_EN` defined:
  - A counter increments each cycle while `inflight` > 0 and no R/B handshake occurs; it clears otherwise.
  - On reaching `TIMEOUT_CYCLES`, the bridge pushes {0, err = 1} for the oldest transaction, decrements `inflight`, increments `drop_cnt`, and clears the counter.
  - Later R/B beats while `drop_cnt` > 0 decrement `drop_cnt` and are not pushed.
- Not defined: no counter or `drop_cnt`; a transaction may remain outstanding forever.

## Test plan
- **Single read:** read `0x8000_0010` size 2, slave returns `0xDEADBEEF` OKAY after 3 cycles → `arvalid` at N+1, `araddr` `0x8000_0010`, `arsize` 2; `rsp_rdata` `0xDEADBEEF`, `rsp_err` 0, one cycle after R handshake.
- **Write with split handshakes:** write `0x100`, data `0x1234_5678`, strb `0x3`, size 1; `awready` at N+1, `wready` at N+4 → each valid drops after its own handshake; `req_ready` stays low until N+4; B OKAY → `rsp_err` 0.
- **Pipelined reads, back-pressure:** `MAX_OUTSTANDING` = 2, 3 back-to-back reads, `rsp_ready` = 0 → third `req_ready` low until first rsp popped; responses delivered in order.
- **Type switch:** read then write issued while the read is outstanding → `req_ready` low until R beat received; write AW appears the cycle after accept.
- **Error response:** `bresp` = 2'b10 → `rsp_err` 1, `rsp_rdata` 0.
- **Timeout (macro on):** `TIMEOUT_CYCLES` = 16, slave never responds → `rsp_err` 1 exactly 16 cycles after AR handshake; a late R beat is then discarded and does not produce a second response.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// AXI4 manager/subordinate channel bundles shared by NoC-attached blocks.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package ravenoc_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 4;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // Signals driven by the AXI manager.
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awlock;
    logic [3:0]                  awcache;
    logic [2:0]                  awprot;
    logic [3:0]                  awqos;
    logic [3:0]                  awregion;
    logic                        awvalid;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        bready;
    logic [AXI_ID_WIDTH-1:0]     arid;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arlock;
    logic [3:0]                  arcache;
    logic [2:0]                  arprot;
    logic [3:0]                  arqos;
    logic [3:0]                  arregion;
    logic                        arvalid;
    logic                        rready;
  } s_axi_mosi_t;

  // Signals driven by the AXI subordinate.
  typedef struct packed {
    logic                      awready;
    logic                      wready;
    logic [AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      arready;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/core_axi_lsu_bridge_if.sv
// Core-side load/store request and response handshake bundle.
// Latency: n/a (wiring only).
// Backpressure: req via req_ready, rsp via rsp_ready.
interface core_axi_lsu_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Core side issues requests and consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Bridge side accepts requests and produces responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/core_axi_lsu_bridge.sv
// Core load/store port to single-ID AXI4 manager, multiple same-type outstanding, in-order responses.
// Latency: accept -> AR/AW/W valid next cycle; R/B handshake -> rsp_valid next cycle.
// Backpressure: credit-limited req_ready; R/B always ready. Optional watchdog: CORE_AXI_LSU_BRIDGE_TIMEOUT_EN.
module core_axi_lsu_bridge
  import ravenoc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int AXI_ID          = 0,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       arst,
  core_axi_lsu_bridge_if.slave       core,
  input  s_axi_miso_t                axi_miso,
  output s_axi_mosi_t                axi_mosi
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CR  = CW'(MAX_OUTSTANDING);
  localparam logic [IW-1:0] LAST_IX = IW'(MAX_OUTSTANDING - 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AXI_ID_WIDTH-1:0] ID_VAL = AXI_ID_WIDTH'(AXI_ID);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_ent_t;

  // Holding register and per-channel pending flags
  logic [31:0] hold_addr;
  logic        hold_we;
  logic [1:0]  hold_size;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_wstrb;
  logic        aw_pend, w_pend, ar_pend;

  logic [CW-1:0] credit;
  logic [CW-1:0] inflight;
  logic          cur_we;

  rsp_ent_t      mem [MAX_OUTSTANDING];
  logic [IW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fcnt;

  logic busy, aw_hs, w_hs, ar_hs, free_evt, acc, pop;
  logic r_hs, b_hs, beat, live_beat, ovf, push, tmo_fire, drop_beat;
  logic rsp_vld_int;
  rsp_ent_t beat_ent, push_ent, head_ent;

  logic unused_miso;
  assign unused_miso = ^{axi_miso.bid, axi_miso.rid, axi_miso.rlast,
                         axi_miso.rresp[0], axi_miso.bresp[0], hold_we};

  assign busy  = aw_pend | w_pend | ar_pend;
  assign aw_hs = aw_pend & axi_miso.awready;
  assign w_hs  = w_pend & axi_miso.wready;
  assign ar_hs = ar_pend & axi_miso.arready;
  // Holding empties this cycle once every pending channel has (or had) its handshake.
  assign free_evt = busy & ~((aw_pend & ~aw_hs) | (w_pend & ~w_hs) | (ar_pend & ~ar_hs));

  // A slot freeing this cycle may be refilled the same cycle, giving one read per cycle.
  // Type switch only once nothing of the old type is held or in flight, keeping one ID in order.
  assign core.req_ready = arst & (~busy | free_evt) & (credit < MAX_CR) &
                          (((inflight == '0) & ~busy) | (core.req_we == cur_we));
  assign acc = core.req_valid & core.req_ready;

  // R/B are always accepted outside reset; credit guarantees buffer space.
  assign r_hs = axi_miso.rvalid & arst;
  assign b_hs = axi_miso.bvalid & arst;
  assign beat = r_hs | b_hs;
  assign beat_ent = r_hs ? '{rdata: axi_miso.rdata, err: axi_miso.rresp[1]}
                         : '{rdata: 32'h0, err: axi_miso.bresp[1]};

`ifdef CORE_AXI_LSU_BRIDGE_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] drop_cnt;

  assign drop_beat = beat & (drop_cnt != '0);
  assign tmo_fire  = (inflight != '0) & ~beat & (tmo_cnt == TMO_LIM);

  // Watchdog: count idle cycles with work in flight, retire the oldest on expiry
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      tmo_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (tmo_fire || beat || inflight == '0) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_fire)       drop_cnt <= drop_cnt + 1'b1;
      else if (drop_beat) drop_cnt <= drop_cnt - 1'b1;
    end
  end
`else
  logic [TW-1:0] unused_tmo_lim;
  assign unused_tmo_lim = TMO_LIM;
  assign drop_beat = 1'b0;
  assign tmo_fire  = 1'b0;
`endif

  // A beat with nothing outstanding (and nothing timed out) is a protocol error and is dropped.
  assign ovf       = beat & (inflight == '0) & ~drop_beat;
  assign live_beat = beat & (inflight != '0) & ~drop_beat;
  assign push      = live_beat | tmo_fire;
  assign push_ent  = tmo_fire ? '{rdata: 32'h0, err: 1'b1} : beat_ent;

  assign rsp_vld_int    = (fcnt != '0);
  assign head_ent       = mem[rd_ptr];
  assign pop            = rsp_vld_int & core.rsp_ready;
  assign core.rsp_valid = rsp_vld_int;
  assign core.rsp_rdata = rsp_vld_int ? head_ent.rdata : 32'h0;
  assign core.rsp_err   = rsp_vld_int & head_ent.err;

  // Capture accepted request, retire channel flags on their own handshakes
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      hold_addr  <= '0;
      hold_we    <= 1'b0;
      hold_size  <= '0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      ar_pend    <= 1'b0;
      cur_we     <= 1'b0;
    end else if (acc) begin
      hold_addr  <= core.req_addr;
      hold_we    <= core.req_we;
      hold_size  <= core.req_size;
      hold_wdata <= core.req_wdata;
      hold_wstrb <= core.req_wstrb;
      aw_pend    <= core.req_we;
      w_pend     <= core.req_we;
      ar_pend    <= ~core.req_we;
      cur_we     <= core.req_we;
    end else begin
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
      if (ar_hs) ar_pend <= 1'b0;
    end
  end

  // Track credits (held + in flight + buffered) and AXI transactions in flight
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      credit   <= '0;
      inflight <= '0;
    end else begin
      credit   <= credit + CW'(acc) - CW'(pop);
      inflight <= inflight + CW'(free_evt) - CW'(push);
    end
  end

  // Response FIFO, push and pop may coincide
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= (wr_ptr == LAST_IX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_IX) ? '0 : rd_ptr + 1'b1;
      fcnt <= fcnt + CW'(push) - CW'(pop);
    end
  end

  // AXI outputs straight from registered holding state; fixed single-beat INCR attributes
  always_comb begin
    axi_mosi         = '0;
    axi_mosi.awid    = ID_VAL;
    axi_mosi.awaddr  = hold_addr;
    axi_mosi.awsize  = {1'b0, hold_size};
    axi_mosi.awburst = AXI_BURST_INCR;
    axi_mosi.awvalid = aw_pend;
    axi_mosi.wdata   = hold_wdata;
    axi_mosi.wstrb   = hold_wstrb;
    axi_mosi.wlast   = 1'b1;
    axi_mosi.wvalid  = w_pend;
    axi_mosi.bready  = arst;
    axi_mosi.arid    = ID_VAL;
    axi_mosi.araddr  = hold_addr;
    axi_mosi.arsize  = {1'b0, hold_size};
    axi_mosi.arburst = AXI_BURST_INCR;
    axi_mosi.arvalid = ar_pend;
    axi_mosi.rready  = arst;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!arst) !ovf);

endmodule

// File: tb/tb_core_axi_lsu_bridge.sv
// Directed bench for core_axi_lsu_bridge: reset, read, split write, pipelining, type switch, errors.
// Inputs driven 1ns after the rising edge, outputs sampled after a further 1ns settle.
// Watchdog section runs only when CORE_AXI_LSU_BRIDGE_TIMEOUT_EN is defined.
module tb_core_axi_lsu_bridge;
  import ravenoc_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  s_axi_miso_t miso;
  s_axi_mosi_t mosi;
  int          checks = 0;
  int          failures = 0;

  core_axi_lsu_bridge_if bus ();

  core_axi_lsu_bridge #(
    .MAX_OUTSTANDING(2),
    .AXI_ID(0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .arst(arst),
    .core(bus),
    .axi_miso(miso),
    .axi_mosi(mosi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
  endtask

  initial begin
    arst          = 1'b0;
    miso          = '0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b1;

    // ---- reset state ----
    #12;
    bus.req_valid = 1'b1;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_valids", {mosi.arvalid, mosi.awvalid, mosi.wvalid}, 0);
    check("rst_readies", {mosi.rready, mosi.bready}, 0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    tick();
    check("post_rst_readies", {mosi.rready, mosi.bready}, 2'b11);
    check("post_rst_req_ready", bus.req_ready, 1);

    // ---- single read ----
    req(1'b0, 32'h8000_0010, 2'd2, 32'h0, 4'h0);
    #1;
    check("rd1_req_ready", bus.req_ready, 1);
    tick();                                   // accept edge N
    bus.req_valid = 1'b0;
    #1;
    check("rd1_arvalid", mosi.arvalid, 1);
    check("rd1_araddr", mosi.araddr, 32'h8000_0010);
    check("rd1_arsize", mosi.arsize, 2);
    check("rd1_arburst", mosi.arburst, 1);
    check("rd1_arlen", mosi.arlen, 0);
    tick();
    check("rd1_ar_stable", mosi.arvalid, 1);
    miso.arready = 1'b1;
    tick();                                   // AR handshake
    miso.arready = 1'b0;
    #1;
    check("rd1_ar_drop", mosi.arvalid, 0);
    tick();
    tick();
    miso.rvalid = 1'b1;
    miso.rdata  = 32'hDEAD_BEEF;
    miso.rresp  = 2'b00;
    #1;
    check("rd1_rsp_early", bus.rsp_valid, 0);
    tick();                                   // R handshake
    miso.rvalid = 1'b0;
    #1;
    check("rd1_rsp_valid", bus.rsp_valid, 1);
    check("rd1_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("rd1_rsp_err", bus.rsp_err, 0);
    tick();
    check("rd1_rsp_popped", bus.rsp_valid, 0);

    // ---- write with split handshakes ----
    req(1'b1, 32'h0000_0100, 2'd1, 32'h1234_5678, 4'h3);
    tick();                                   // accept edge N
    bus.req_valid = 1'b0;
    #1;
    check("wr_awvalid", mosi.awvalid, 1);
    check("wr_wvalid", mosi.wvalid, 1);
    check("wr_awaddr", mosi.awaddr, 32'h100);
    check("wr_awsize", mosi.awsize, 1);
    check("wr_wdata", mosi.wdata, 32'h1234_5678);
    check("wr_wstrb", mosi.wstrb, 4'h3);
    check("wr_wlast", mosi.wlast, 1);
    miso.awready = 1'b1;
    tick();                                   // N+1: AW handshake
    miso.awready = 1'b0;
    #1;
    check("wr_aw_drop", mosi.awvalid, 0);
    check("wr_w_hold", mosi.wvalid, 1);
    check("wr_ready_n1", bus.req_ready, 0);
    tick();
    tick();                                   // N+3
    check("wr_w_hold_n3", mosi.wvalid, 1);
    check("wr_ready_n3", bus.req_ready, 0);
    miso.wready = 1'b1;
    tick();                                   // N+4: W handshake
    miso.wready = 1'b0;
    #1;
    check("wr_w_drop", mosi.wvalid, 0);
    check("wr_ready_n4", bus.req_ready, 1);
    miso.bvalid = 1'b1;
    miso.bresp  = 2'b00;
    tick();
    miso.bvalid = 1'b0;
    #1;
    check("wr_rsp_valid", bus.rsp_valid, 1);
    check("wr_rsp_err", bus.rsp_err, 0);
    check("wr_rsp_rdata", bus.rsp_rdata, 0);
    tick();

    // ---- pipelined reads with response back-pressure ----
    bus.rsp_ready = 1'b0;
    miso.arready  = 1'b1;
    req(1'b0, 32'h40, 2'd2, 32'h0, 4'h0);
    #1;
    check("pipe_ready0", bus.req_ready, 1);
    tick();
    bus.req_addr = 32'h44;
    #1;
    check("pipe_ready1", bus.req_ready, 1);
    check("pipe_araddr0", mosi.araddr, 32'h40);
    tick();
    bus.req_addr = 32'h48;
    #1;
    check("pipe_ready2_blocked", bus.req_ready, 0);
    check("pipe_araddr1", mosi.araddr, 32'h44);
    tick();
    check("pipe_ready2_still", bus.req_ready, 0);
    check("pipe_ar_idle", mosi.arvalid, 0);
    miso.rvalid = 1'b1;
    miso.rdata  = 32'h1111_0000;
    tick();
    miso.rdata = 32'h2222_0001;
    #1;
    check("pipe_rsp0_valid", bus.rsp_valid, 1);
    check("pipe_rsp0_data", bus.rsp_rdata, 32'h1111_0000);
    tick();
    miso.rvalid = 1'b0;
    #1;
    check("pipe_full_ready", bus.req_ready, 0);
    check("pipe_rsp0_held", bus.rsp_rdata, 32'h1111_0000);
    bus.rsp_ready = 1'b1;
    tick();                                   // pop first response
    check("pipe_rsp1_data", bus.rsp_rdata, 32'h2222_0001);
    check("pipe_ready_after_pop", bus.req_ready, 1);
    tick();                                   // pop second, accept third
    bus.req_valid = 1'b0;
    #1;
    check("pipe_ar2_valid", mosi.arvalid, 1);
    check("pipe_araddr2", mosi.araddr, 32'h48);
    check("pipe_fifo_empty", bus.rsp_valid, 0);
    tick();                                   // AR handshake
    miso.rvalid = 1'b1;
    miso.rdata  = 32'h3333_0002;
    tick();
    miso.rvalid = 1'b0;
    #1;
    check("pipe_rsp2_data", bus.rsp_rdata, 32'h3333_0002);
    tick();

    // ---- type switch, then error B response ----
    req(1'b0, 32'h200, 2'd2, 32'h0, 4'h0);
    tick();                                   // read accepted
    req(1'b1, 32'h300, 2'd2, 32'hCAFE_F00D, 4'hF);
    #1;
    check("sw_ready_held", bus.req_ready, 0);
    tick();                                   // AR handshake
    check("sw_ready_inflight", bus.req_ready, 0);
    check("sw_no_aw", mosi.awvalid, 0);
    miso.rvalid = 1'b1;
    miso.rdata  = 32'h0000_0055;
    miso.rresp  = 2'b00;
    tick();                                   // R handshake
    miso.rvalid = 1'b0;
    #1;
    check("sw_ready_open", bus.req_ready, 1);
    check("sw_rd_rsp", bus.rsp_rdata, 32'h55);
    tick();                                   // write accepted
    bus.req_valid = 1'b0;
    #1;
    check("sw_awvalid", mosi.awvalid, 1);
    check("sw_awaddr", mosi.awaddr, 32'h300);
    check("sw_wvalid", mosi.wvalid, 1);
    miso.awready = 1'b1;
    miso.wready  = 1'b1;
    tick();
    miso.awready = 1'b0;
    miso.wready  = 1'b0;
    miso.bvalid  = 1'b1;
    miso.bresp   = 2'b10;
    tick();
    miso.bvalid = 1'b0;
    #1;
    check("err_rsp_valid", bus.rsp_valid, 1);
    check("err_rsp_err", bus.rsp_err, 1);
    check("err_rsp_rdata", bus.rsp_rdata, 0);
    tick();

    // ---- reset mid-operation ----
    miso.arready = 1'b0;
    req(1'b0, 32'h500, 2'd2, 32'h0, 4'h0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    check("mid_arvalid", mosi.arvalid, 1);
    arst = 1'b0;
    #1;
    check("mid_rst_arvalid", mosi.arvalid, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_rready", mosi.rready, 0);
    @(negedge clk);
    arst = 1'b1;
    tick();
    check("mid_post_ready", bus.req_ready, 1);
    check("mid_post_arvalid", mosi.arvalid, 0);

`ifdef CORE_AXI_LSU_BRIDGE_TIMEOUT_EN
    // ---- watchdog expiry and late-beat discard ----
    miso.arready = 1'b1;
    req(1'b0, 32'h600, 2'd2, 32'h0, 4'h0);
    tick();                                   // accept
    bus.req_valid = 1'b0;
    tick();                                   // AR handshake edge M
    miso.arready = 1'b0;
    for (int i = 0; i < 15; i++) tick();      // edge M+15
    check("tmo_not_yet", bus.rsp_valid, 0);
    tick();                                   // edge M+16
    check("tmo_rsp_valid", bus.rsp_valid, 1);
    check("tmo_rsp_err", bus.rsp_err, 1);
    check("tmo_rsp_rdata", bus.rsp_rdata, 0);
    tick();                                   // popped
    miso.rvalid = 1'b1;
    miso.rdata  = 32'h0000_0077;
    tick();                                   // late beat discarded
    miso.rvalid = 1'b0;
    #1;
    check("tmo_late_dropped", bus.rsp_valid, 0);
    tick();
    check("tmo_late_dropped2", bus.rsp_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
